mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS32 datapath. It sits directly downstream of the register file: it consumes the two read ports (Da → a, Db → b) when MULT/MULTU/DIV/DIVU issues. It returns results through the HI/LO read port, which feeds the register-file write data path for MFHI/MFLO. One operation is in flight at a time, under a start/busy/done handshake.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : operation encodings driven on the op port
//   - mdu_state_e : sequencing FSM states
//   - HILO_LO/HI  : register select values for mt_sel and hilo_sel
//   - op_is_signed/op_is_div : operation decode helpers
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIX
    } mdu_state_e;

    localparam logic HILO_LO = 1'b0;
    localparam logic HILO_HI = 1'b1;

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, op, a, b     issue request (sampled only in IDLE), opcode, operands
//   mt_we, mt_sel,      MTHI/MTLO write port (IDLE only, start has priority)
//   mt_din
//   hilo_sel, hilo_out  combinational HI/LO read port
//   busy, done          busy while not IDLE; one-cycle done when HI/LO update
// Both operations run on operand magnitudes in one 2*WIDTH accumulator and
// apply sign correction once in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_din,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e         state, state_next;
    mdu_op_e            op_in, op_q;
    logic               in_signed;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic [WIDTH-1:0]   a_q, mag_a, mag_b;
    logic               neg_q, neg_rem, b_zero;
    logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
    logic [WIDTH:0]     mul_sum, trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic               done_q;

    assign op_in     = mdu_op_e'(op);
    assign in_signed = op_is_signed(op_in);
    // Two's-complement negation of the most negative value wraps to itself,
    // which read as unsigned is exactly its magnitude.
    assign mag_a_c   = (in_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b_c   = (in_signed && b[WIDTH-1]) ? -b : b;

    // NOTE: non-blocking assignments in every clocked block so all registers
    // update from the same pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned
        // and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration of each algorithm, selected by the latched opcode.
    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand on a 1 bit, then shift right with the carry.
    // Divide: acc = {partial remainder, dividend/quotient bits}; shift left,
    // trial-subtract the divisor, keep the difference if it did not borrow.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        if (op_is_div(op_q)) begin
            acc_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        prod_fix = neg_q   ? -acc : acc;
        quo_fix  = neg_q   ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // NOTE: operand and working registers are deliberately not reset; they are
    // always loaded before use, and only the architectural/control state needs
    // a defined value after reset.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: if (start) begin
                op_q    <= op_in;
                a_q     <= a;
                mag_a   <= mag_a_c;
                mag_b   <= mag_b_c;
                neg_q   <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= in_signed && a[WIDTH-1];
                b_zero  <= (b == '0);
            end
            PREP:    acc <= {{WIDTH{1'b0}}, op_is_div(op_q) ? mag_a : mag_b};
            CALC:    acc <= acc_next;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (!start && mt_we) begin
                    if (mt_sel == HILO_HI) hi <= mt_din;
                    else                   lo <= mt_din;
                end
                PREP: cnt <= '0;
                CALC: cnt <= cnt + CNT_W'(1);
                FIX: begin
                    done_q <= 1'b1;
                    cnt    <= '0;
                    if (!op_is_div(op_q)) begin
                        {hi, lo} <= prod_fix;
                    end else if (b_zero) begin
                        // Divide by zero returns the raw dividend rather than
                        // the magnitude loop's remainder.
                        hi <= a_q;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign hilo_out = (hilo_sel == HILO_HI) ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected HI/LO and the
// expected done cycle into a scoreboard; a monitor pops on each done pulse.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mt_we = 1'b0;
    logic         mt_sel = 1'b0;
    logic [W-1:0] mt_din = '0;
    logic         hilo_sel;
    logic [W-1:0] hilo_out;
    logic         busy;
    logic         done;

    // The monitor borrows the read port only during done cycles.
    logic mon_rd = 1'b0;
    logic mon_sel = 1'b0;
    logic stim_sel = 1'b0;
    assign hilo_sel = mon_rd ? mon_sel : stim_sel;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
        string        name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string        name;
        mdu_op_e      op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10] = '{
        '{"mult_neg",     MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE},
        '{"multu",        MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE},
        '{"multu_max",    MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{"mult_min_sq",  MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{"div_neg_a",    MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{"div_neg_b",    MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{"divu",         MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003},
        '{"divu_zero",    MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
        '{"div_zero_neg", MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF},
        '{"div_ovf",      MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}
    };

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .mt_we    (mt_we),
        .mt_sel   (mt_sel),
        .mt_din   (mt_din),
        .hilo_sel (hilo_sel),
        .hilo_out (hilo_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd(input logic s, output logic [W-1:0] v);
        stim_sel = s;
        #1 v = hilo_out;
    endtask

    // Drives start at the current (negedge) time; done is due 34 edges after
    // the sampling edge, i.e. cycle counter value now + 1 + 34.
    task automatic issue(input string name, input logic [1:0] o,
                         input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit exp_on, input logic [W-1:0] eh, input logic [W-1:0] el);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        if (exp_on) sb.push_back('{hi: eh, lo: el, due: cyc + 35, name: name});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            failed++;
            $display("FAIL %s_timeout: no done within 60 cycles, required done=1", name);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [W-1:0] rh, rl;
        if (done) begin
            mon_rd  = 1'b1;
            mon_sel = HILO_HI;
            #1 rh = hilo_out;
            mon_sel = HILO_LO;
            #1 rl = hilo_out;
            mon_rd = 1'b0;
            check("busy_in_done", W'(busy), W'(0));
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL spurious_done: done=1 at cycle %0d, required no outstanding op", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, rh, e.hi);
                check({e.name, "_lo"}, rl, e.lo);
                check({e.name, "_latency"}, W'(cyc), W'(e.due));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [W-1:0] v;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        rd(HILO_HI, v); check("rst_hi", v, '0);
        rd(HILO_LO, v); check("rst_lo", v, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTLO / MTHI in IDLE.
        mt_we = 1'b1; mt_sel = HILO_LO; mt_din = 32'h12345678;
        @(negedge clk);
        mt_we = 1'b0;
        rd(HILO_LO, v); check("mtlo", v, 32'h12345678);
        mt_we = 1'b1; mt_sel = HILO_HI; mt_din = 32'h0BADF00D;
        @(negedge clk);
        mt_we = 1'b0;
        rd(HILO_HI, v); check("mthi", v, 32'h0BADF00D);

        // start and mt_we together: the op wins, MTLO is dropped, and HI/LO
        // keep their pre-operation values while busy.
        mt_we = 1'b1; mt_sel = HILO_LO; mt_din = 32'h5555AAAA;
        issue("mt_collide", MDU_MULTU, 32'h00010000, 32'h00010000, 1'b1, 32'h00000001, 32'h00000000);
        mt_we = 1'b0;
        check("collide_busy", W'(busy), W'(1));
        rd(HILO_LO, v); check("collide_lo_pre", v, 32'h12345678);
        rd(HILO_HI, v); check("collide_hi_pre", v, 32'h0BADF00D);
        wait_done("mt_collide");

        // Directed vectors, each issued in the previous op's done cycle.
        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo);
            wait_done(vecs[i].name);
        end

        // Second start and an MTLO while busy are both ignored.
        issue("divu_busy", MDU_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        check("busy_after_start", W'(busy), W'(1));
        repeat (3) @(negedge clk);
        start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        mt_we = 1'b1; mt_sel = HILO_LO; mt_din = 32'hDEADBEEF;
        @(negedge clk);
        mt_we = 1'b0;
        rd(HILO_LO, v); check("busy_mt_ignored", v, 32'h80000000);
        wait_done("divu_busy");

        // Reset at cycle 10 of a MULT abandons it and clears HI/LO.
        issue("mult_abort", MDU_MULT, 32'd123, 32'd456, 1'b0, '0, '0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        rd(HILO_HI, v); check("abort_hi", v, '0);
        rd(HILO_LO, v); check("abort_lo", v, '0);
        rst_n = 1'b1;
        @(negedge clk);
        issue("multu_after_rst", MDU_MULTU, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30);
        wait_done("multu_after_rst");

        repeat (4) @(negedge clk);
        rd(HILO_LO, v); check("final_lo", v, 32'd30);
        check("sb_drained", W'(sb.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
